// File: rtl/qsram_refresh_controller.sv
`default_nettype none
// ============================================================================
// Module      : qsram_refresh_controller
// Description : Row-organised QSRAM control stage. Serialises host read and
//               write requests against periodic row refresh, and drives the
//               one-hot RowSelect plus Read/Write/Refresh edge strobes.
//               Optional macro QSRAM_REFRESH_OVERRUN_EN adds a saturating
//               RefreshOverrunCount output.
// Revision    : 1.0 - initial release
// ============================================================================
module qsram_refresh_controller #(
    parameter int ROWS             = 16,
    parameter int ADDR_WIDTH       = 4,
    parameter int COLS             = 8,
    parameter int REFRESH_INTERVAL = 64,
    parameter int TIMER_WIDTH      = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Request,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [COLS-1:0]       WriteData,
    output logic                  Acknowledge,
    output logic [COLS-1:0]       ReadData,
    output logic                  Busy,
    output logic [ROWS-1:0]       RowSelect,
    output logic                  ReadEdge,
    output logic                  WriteEdge,
    output logic                  RefreshEdge,
    output logic [COLS-1:0]       ArrayInputData,
    input  logic [COLS-1:0]       ArrayOutputData
`ifdef QSRAM_REFRESH_OVERRUN_EN
    ,
    output logic [7:0]            RefreshOverrunCount
`endif
);

    localparam logic [TIMER_WIDTH-1:0] c_TIMER_LAST = TIMER_WIDTH'(REFRESH_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0]  c_ROW_LAST   = ADDR_WIDTH'(ROWS - 1);
    localparam logic [ADDR_WIDTH:0]    c_ROWS_EXT   = (ADDR_WIDTH + 1)'(ROWS);
    localparam logic [ROWS-1:0]        c_ROW_ONE    = ROWS'(1);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        READ_PULSE      = 3'd1,
        READ_CAPTURE    = 3'd2,
        WRITE_PULSE     = 3'd3,
        ACK             = 3'd4,
        REFRESH_PULSE   = 3'd5,
        REFRESH_RECOVER = 3'd6
    } stateType;

    stateType              r_state;
    stateType              w_nextState;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                  r_refreshPending;
    logic [ADDR_WIDTH-1:0] r_refreshRow;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [COLS-1:0]       r_writeData;
    logic [COLS-1:0]       r_readData;

    logic w_timerWrap;
    logic w_takeRefresh;
    logic w_accept;
    logic w_addrValid;

    assign w_timerWrap   = (r_timer == c_TIMER_LAST);
    assign w_takeRefresh = (r_state == IDLE) && r_refreshPending;
    assign w_accept      = (r_state == IDLE) && !r_refreshPending && Request;
    assign w_addrValid   = ({1'b0, Address} < c_ROWS_EXT);

    // State register; a reset simply abandons any in-flight operation
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: refresh has priority over a waiting host request in IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (r_refreshPending) begin
                    w_nextState = REFRESH_PULSE;
                end else if (Request) begin
                    if (!w_addrValid) begin
                        w_nextState = ACK;
                    end else if (WriteEnable) begin
                        w_nextState = WRITE_PULSE;
                    end else begin
                        w_nextState = READ_PULSE;
                    end
                end
            end
            READ_PULSE:      w_nextState = READ_CAPTURE;
            READ_CAPTURE:    w_nextState = ACK;
            WRITE_PULSE:     w_nextState = ACK;
            ACK:             w_nextState = IDLE;
            REFRESH_PULSE:   w_nextState = REFRESH_RECOVER;
            REFRESH_RECOVER: w_nextState = IDLE;
            default:         w_nextState = IDLE;
        endcase
    end

    // Array-side outputs decoded purely from state and latched operands
    always_comb begin
        RowSelect      = '0;
        ReadEdge       = 1'b0;
        WriteEdge      = 1'b0;
        RefreshEdge    = 1'b0;
        ArrayInputData = '0;
        case (r_state)
            READ_PULSE: begin
                ReadEdge  = 1'b1;
                RowSelect = c_ROW_ONE << r_address;
            end
            READ_CAPTURE: begin
                RowSelect = c_ROW_ONE << r_address;
            end
            WRITE_PULSE: begin
                WriteEdge      = 1'b1;
                RowSelect      = c_ROW_ONE << r_address;
                ArrayInputData = r_writeData;
            end
            REFRESH_PULSE: begin
                RefreshEdge = 1'b1;
                RowSelect   = c_ROW_ONE << r_refreshRow;
            end
            default: begin
            end
        endcase
    end

    assign Acknowledge = (r_state == ACK);
    assign Busy        = (r_state != IDLE);
    assign ReadData    = r_readData;

    // Free-running refresh timer; a wrap queues one refresh, extra wraps are dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_timer          <= '0;
            r_refreshPending <= 1'b0;
        end else begin
            if (w_timerWrap) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_WIDTH'(1);
            end
            if (w_takeRefresh) begin
                r_refreshPending <= 1'b0;
            end else if (w_timerWrap) begin
                r_refreshPending <= 1'b1;
            end
        end
    end

    // Refresh row pointer advances once the refresh pulse has completed
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_refreshRow <= '0;
        end else if (r_state == REFRESH_RECOVER) begin
            if (r_refreshRow == c_ROW_LAST) begin
                r_refreshRow <= '0;
            end else begin
                r_refreshRow <= r_refreshRow + ADDR_WIDTH'(1);
            end
        end
    end

    // Host operand latch at accept; out-of-range reads return zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_address   <= '0;
            r_writeData <= '0;
            r_readData  <= '0;
        end else begin
            if (w_accept) begin
                r_address   <= Address;
                r_writeData <= WriteData;
                if (!w_addrValid && !WriteEnable) begin
                    r_readData <= '0;
                end
            end
            if (r_state == READ_CAPTURE) begin
                r_readData <= ArrayOutputData;
            end
        end
    end

`ifdef QSRAM_REFRESH_OVERRUN_EN
    logic [7:0] r_overrunCount;

    // Count timer wraps that arrive while a refresh is still outstanding
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_overrunCount <= '0;
        end else if (w_timerWrap && r_refreshPending && (r_overrunCount != 8'hFF)) begin
            r_overrunCount <= r_overrunCount + 8'd1;
        end
    end

    assign RefreshOverrunCount = r_overrunCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qsram_refresh_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsram_refresh_controller
// Description : Directed self-checking bench for qsram_refresh_controller.
//               Expected acknowledges are queued at request time and matched
//               by a monitor; strobe timing is checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsram_refresh_controller;

    localparam int ROWS       = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int COLS       = 8;

    logic                  Clock = 1'b0;
    logic                  Reset = 1'b1;
    logic                  Request = 1'b0;
    logic                  WriteEnable = 1'b0;
    logic [ADDR_WIDTH-1:0] Address = '0;
    logic [COLS-1:0]       WriteData = '0;
    logic [COLS-1:0]       ArrayOutputData = '0;
    logic                  Acknowledge;
    logic [COLS-1:0]       ReadData;
    logic                  Busy;
    logic [ROWS-1:0]       RowSelect;
    logic                  ReadEdge;
    logic                  WriteEdge;
    logic                  RefreshEdge;
    logic [COLS-1:0]       ArrayInputData;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int              ackCycle;
        logic            isRead;
        logic [COLS-1:0] data;
    } expT;

    expT sb[$];
    expT mon;

`ifdef QSRAM_REFRESH_OVERRUN_EN
    logic [7:0] ovr;
`endif

    qsram_refresh_controller #(
        .ROWS(ROWS), .ADDR_WIDTH(ADDR_WIDTH), .COLS(COLS),
        .REFRESH_INTERVAL(64), .TIMER_WIDTH(8)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Request(Request),
        .WriteEnable(WriteEnable), .Address(Address), .WriteData(WriteData),
        .Acknowledge(Acknowledge), .ReadData(ReadData), .Busy(Busy),
        .RowSelect(RowSelect), .ReadEdge(ReadEdge), .WriteEdge(WriteEdge),
        .RefreshEdge(RefreshEdge), .ArrayInputData(ArrayInputData),
        .ArrayOutputData(ArrayOutputData)
`ifdef QSRAM_REFRESH_OVERRUN_EN
        , .RefreshOverrunCount(ovr)
`endif
    );

`ifdef QSRAM_REFRESH_OVERRUN_EN
    logic                  ack2, busy2, re2, we2, rf2;
    logic [COLS-1:0]       rd2, aid2;
    logic [ROWS-1:0]       rs2;
    logic [7:0]            ovr2;
    logic                  req2 = 1'b1;
    logic [ADDR_WIDTH-1:0] addr2 = '0;
    logic [COLS-1:0]       zero2 = '0;

    qsram_refresh_controller #(
        .ROWS(ROWS), .ADDR_WIDTH(ADDR_WIDTH), .COLS(COLS),
        .REFRESH_INTERVAL(2), .TIMER_WIDTH(8)
    ) dut2 (
        .Clock(Clock), .Reset(Reset), .Request(req2),
        .WriteEnable(1'b0), .Address(addr2), .WriteData(zero2),
        .Acknowledge(ack2), .ReadData(rd2), .Busy(busy2),
        .RowSelect(rs2), .ReadEdge(re2), .WriteEdge(we2),
        .RefreshEdge(rf2), .ArrayInputData(aid2),
        .ArrayOutputData(zero2), .RefreshOverrunCount(ovr2)
    );
`endif

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge Clock) begin
        if (Acknowledge) begin
            if (sb.size() == 0) begin
                checks++;
                if (Acknowledge !== 1'b0) fail("unexpectedAck", Acknowledge, 1'b0);
            end else begin
                mon = sb.pop_front();
                checks++;
                if (cyc !== mon.ackCycle) fail("ackCycle", cyc, mon.ackCycle);
                if (mon.isRead) begin
                    checks++;
                    if (ReadData !== mon.data) fail("readData", ReadData, mon.data);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].ackCycle) begin
            checks++;
            if (cyc !== sb[0].ackCycle) fail("ackTimeout", cyc, sb[0].ackCycle);
            void'(sb.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset   = 1'b1;
        Request = 1'b0;
        sb.delete();
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic startOp(input logic we, input int addr, input logic [COLS-1:0] wd,
                           input int lat, input logic [COLS-1:0] expData);
        Request     = 1'b1;
        WriteEnable = we;
        Address     = ADDR_WIDTH'(addr);
        WriteData   = wd;
        sb.push_back('{cyc + lat, !we, expData});
    endtask

    int              r;
    int              k;
    logic [ROWS-1:0] expRow;

    initial begin
        #1;
        doReset();

        startOp(1'b1, 3, 8'hA5, 2, 8'h00);
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0) fail("rstBusy", Busy, 1'b0);
        checks++;
        if (RowSelect !== 16'h0000) fail("rstRowSel", RowSelect, 16'h0000);
        checks++;
        if ({ReadEdge, WriteEdge, RefreshEdge} !== 3'b000) fail("rstStrobes", {ReadEdge, WriteEdge, RefreshEdge}, 3'b000);
        checks++;
        if (ReadData !== 8'h00) fail("rstReadData", ReadData, 8'h00);
        checks++;
        if (ArrayInputData !== 8'h00) fail("rstArrayIn", ArrayInputData, 8'h00);
        tick();
        @(negedge Clock);
        checks++;
        if (WriteEdge !== 1'b1) fail("wrEdge", WriteEdge, 1'b1);
        checks++;
        if (RowSelect !== 16'h0008) fail("wrRowSel", RowSelect, 16'h0008);
        checks++;
        if (ArrayInputData !== 8'hA5) fail("wrData", ArrayInputData, 8'hA5);
        checks++;
        if ({ReadEdge, RefreshEdge} !== 2'b00) fail("wrOther", {ReadEdge, RefreshEdge}, 2'b00);
        tick();
        Request = 1'b0;
        @(negedge Clock);
        checks++;
        if (ArrayInputData !== 8'h00) fail("wrAckArrayIn", ArrayInputData, 8'h00);
        tick();

        ArrayOutputData = 8'h5A;
        startOp(1'b0, 3, 8'h00, 3, 8'h5A);
        tick();
        @(negedge Clock);
        checks++;
        if (ReadEdge !== 1'b1) fail("rdEdge", ReadEdge, 1'b1);
        checks++;
        if (RowSelect !== 16'h0008) fail("rdRowSel", RowSelect, 16'h0008);
        tick();
        @(negedge Clock);
        checks++;
        if (ReadEdge !== 1'b0) fail("rdCapEdge", ReadEdge, 1'b0);
        checks++;
        if (RowSelect !== 16'h0008) fail("rdCapRowSel", RowSelect, 16'h0008);
        tick();
        Request = 1'b0;
        tick();
        ArrayOutputData = 8'h11;
        @(negedge Clock);
        checks++;
        if (ReadData !== 8'h5A) fail("rdHold", ReadData, 8'h5A);

        ArrayOutputData = 8'hFF;
        startOp(1'b0, 20, 8'h00, 1, 8'h00);
        tick();
        Request = 1'b0;
        @(negedge Clock);
        checks++;
        if ({ReadEdge, WriteEdge, RefreshEdge} !== 3'b000) fail("badStrobes", {ReadEdge, WriteEdge, RefreshEdge}, 3'b000);
        checks++;
        if (RowSelect !== 16'h0000) fail("badRowSel", RowSelect, 16'h0000);
        tick();

        startOp(1'b1, 7, 8'h3C, 2, 8'h00);
        tick();
        tick();
        Address   = ADDR_WIDTH'(9);
        WriteData = 8'hC3;
        sb.push_back('{cyc + 3, 1'b0, 8'h00});
        tick();
        tick();
        @(negedge Clock);
        checks++;
        if (RowSelect !== 16'h0200) fail("b2bRowSel", RowSelect, 16'h0200);
        checks++;
        if (ArrayInputData !== 8'hC3) fail("b2bData", ArrayInputData, 8'hC3);
        tick();
        Request = 1'b0;
        tick();

        doReset();
        r = cyc;
        k = 0;
        while (cyc < r + 1100) begin
            @(negedge Clock);
            if (RefreshEdge) begin
                expRow = ROWS'(1) << (k % ROWS);
                checks++;
                if (cyc !== r + 65 + 64 * k) fail("refCycle", cyc, r + 65 + 64 * k);
                checks++;
                if (RowSelect !== expRow) fail("refRow", RowSelect, expRow);
                checks++;
                if ({ReadEdge, WriteEdge} !== 2'b00) fail("refOnly", {ReadEdge, WriteEdge}, 2'b00);
                k++;
            end
        end
        checks++;
        if (k !== 17) fail("refCount", k, 17);

        doReset();
        r = cyc;
        repeat (64) tick();
        ArrayOutputData = 8'h3C;
        startOp(1'b0, 5, 8'h00, 6, 8'h3C);
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0) fail("colIdle", Busy, 1'b0);
        tick();
        @(negedge Clock);
        checks++;
        if (RefreshEdge !== 1'b1) fail("colRefEdge", RefreshEdge, 1'b1);
        checks++;
        if (RowSelect !== 16'h0001) fail("colRefRow", RowSelect, 16'h0001);
        checks++;
        if (ReadEdge !== 1'b0) fail("colNoRead", ReadEdge, 1'b0);
        tick();
        @(negedge Clock);
        checks++;
        if ({ReadEdge, WriteEdge, RefreshEdge, Busy} !== 4'b0001) fail("colRecover", {ReadEdge, WriteEdge, RefreshEdge, Busy}, 4'b0001);
        tick();
        tick();
        @(negedge Clock);
        checks++;
        if (ReadEdge !== 1'b1) fail("colRdEdge", ReadEdge, 1'b1);
        checks++;
        if (RowSelect !== 16'h0020) fail("colRdRow", RowSelect, 16'h0020);
        tick();
        tick();
        Request = 1'b0;
        tick();

        ArrayOutputData = 8'h77;
        startOp(1'b0, 2, 8'h00, 3, 8'h77);
        tick();
        @(negedge Clock);
        checks++;
        if (ReadEdge !== 1'b1) fail("mrEdge", ReadEdge, 1'b1);
        Reset   = 1'b1;
        Request = 1'b0;
        sb.delete();
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0) fail("mrBusy", Busy, 1'b0);
        checks++;
        if (RowSelect !== 16'h0000) fail("mrRowSel", RowSelect, 16'h0000);
        checks++;
        if ({ReadEdge, WriteEdge, RefreshEdge, Acknowledge} !== 4'b0000) fail("mrStrobes", {ReadEdge, WriteEdge, RefreshEdge, Acknowledge}, 4'b0000);
        checks++;
        if (ReadData !== 8'h00) fail("mrReadData", ReadData, 8'h00);
        repeat (30) tick();

`ifdef QSRAM_REFRESH_OVERRUN_EN
        @(negedge Clock);
        checks++;
        if ((ovr2 != 8'd0) !== 1'b1) fail("overrunSeen", ovr2, 8'd1);
        checks++;
        if (ovr !== 8'd0) fail("overrunMain", ovr, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
